// File: rtl/uart_tx_fifo_if.sv
// Client-side write handshake for uart_tx_fifo: word plus valid/ready.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_ready;

    // Producer side (command/telemetry client)
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Consumer side (the transmitter)
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO. Queued words are sent
// back-to-back: the stop period of one frame flows straight into the
// start bit of the next with no idle cycles.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               in_bus,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = 4;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

    // Reject unsupported parameter combinations at elaboration.
    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
            FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
            $error("uart_tx_fifo: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Registered state
    state_t               r_state;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_par;
    logic                 r_tx;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];

    // Combinational next-state and control
    state_t               w_state_next;
    logic [CW-1:0]        w_baud_next;
    logic [BW-1:0]        w_bit_cnt_next;
    logic [DATA_BITS-1:0] w_shreg_next;
    logic                 w_par_next;
    logic                 w_tx_next;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_not_empty;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    assign w_not_empty = (r_level != '0);
    assign w_push      = in_bus.in_valid && in_bus.in_ready;
    assign w_bit_end   = (r_baud == BAUD_LAST);

    // The FIFO is read asynchronously so a pop can load the shifter on
    // the same edge that starts the frame. Parity is taken from the
    // head word here, before any shifting happens.
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_par = (PARITY == 1) ? ~(^w_head) : (^w_head);

    assign in_bus.in_ready = (r_level != LEVEL_FULL);
    assign busy            = (r_state != S_IDLE) || w_not_empty;
    assign fifo_level      = r_level;
    assign tx              = r_tx;

    // FIFO storage: data only, no reset so it can map to distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_bus.in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Transmit FSM state register; reset returns the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shreg   <= w_shreg_next;
            r_par     <= w_par_next;
            r_tx      <= w_tx_next;
        end
    end

    // Next-state logic: bit sequencing, baud timing and FIFO pops.
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_cnt_next = r_bit_cnt;
        w_shreg_next   = r_shreg;
        w_par_next     = r_par;
        w_tx_next      = r_tx;
        w_pop          = 1'b0;

        // Baud counter restarts on every bit boundary.
        if (r_state != S_IDLE) begin
            w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_tx_next   = 1'b1;
                w_baud_next = '0;
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_shreg_next = w_head;
                    w_par_next   = w_head_par;
                    w_tx_next    = 1'b0;
                    w_state_next = S_START;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_tx_next      = r_shreg[0];
                    w_shreg_next   = {1'b0, r_shreg[DATA_BITS-1:1]};
                    w_bit_cnt_next = '0;
                    w_state_next   = S_DATA;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_cnt_next = '0;
                        if (PARITY != 0) begin
                            w_tx_next    = r_par;
                            w_state_next = S_PARITY;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = S_STOP;
                        end
                    end else begin
                        w_tx_next      = r_shreg[0];
                        w_shreg_next   = {1'b0, r_shreg[DATA_BITS-1:1]};
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    w_tx_next      = 1'b1;
                    w_bit_cnt_next = '0;
                    w_state_next   = S_STOP;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        w_bit_cnt_next = '0;
                        // Chain straight into the next frame when work is queued.
                        if (w_not_empty) begin
                            w_pop        = 1'b1;
                            w_shreg_next = w_head;
                            w_par_next   = w_head_par;
                            w_tx_next    = 1'b0;
                            w_state_next = S_START;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_tx_next    = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a programmable baud divider, configurable frame format (data bits, parity, stop bits) and a small input FIFO. It sits between a byte-producing client (command/telemetry logic) and the FPGA TX pin. It serialises queued words back-to-back with no idle gap, so the client never has to wait for frame completion.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be >=2.
DATA_BITS, 8, data bits per frame; legal values 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
FIFO_DEPTH, 4, input FIFO entries; power of 2, >=2.

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  client presents a word.
in_data  in  DATA_BITS  word to send; bit 0 is sent first.
in_ready  out  1  FIFO can accept a word; equals (fifo_level != FIFO_DEPTH).
tx  out  1  serial line; registered; idles high.
busy  out  1  high when the FSM is not in IDLE or fifo_level != 0.
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words queued (excludes the word being shifted).

Behaviour:
- Reset (async, any time incl. mid-frame): tx=1, busy=0, in_ready=1, fifo_level=0, FIFO pointers cleared, FSM=IDLE, baud counter=0. The partial frame is abandoned; the line returns high immediately.
- Write: accepted on a clk edge when in_valid && in_ready. in_ready depends only on the current fifo_level; a pop in the same cycle does not raise it.
- Simultaneous write and pop: fifo_level unchanged and data order preserved.
- Read pointer and write pointer wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If fifo_level!=0, pop the head word into the shift register on that edge, set tx<=0 and go to START.
  - Latency: a word written at edge E0 into an empty FIFO with the FSM in IDLE drives tx low from edge E0+1.
- Bit timing: each state holds tx for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and resets on every bit transition.
- START -> DATA: tx<=shreg[0], then shift right once per bit.
- DATA: after DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
- PARITY: tx holds the parity bit.
  - Odd: the parity bit makes the total ones (data + parity) odd.
  - Even: the parity bit makes that total even.
  - Parity is computed from the popped word, not the shifted register.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end of the stop period, if fifo_level!=0, pop, set tx<=0 and enter START on the same edge (zero idle cycles).
  - Otherwise enter IDLE.
- Frame length: (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles exactly.
- in_data changes after acceptance do not affect queued or in-flight frames.
- Illegal parameter values are out of scope; an elaboration-time check is recommended.

Test Plan:
- CLKS_PER_BIT=4, 8N1, write 0x55 once -> tx goes low 1 cycle after the write edge. Bit sequence is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total). busy then falls and tx stays 1.
- PARITY=2 (even), write 0x03 -> parity bit 0. With PARITY=1 (odd), 0x03 -> parity bit 1. Frame is 11 bits = 44 cycles at CLKS_PER_BIT=4.
- Write 0xA1, 0xB2, 0xC3 on consecutive cycles -> three frames with no high gap between the stop bit and the next start bit. Decoded bytes arrive in order and busy stays high throughout.
- FIFO_DEPTH=4, hold in_valid high with distinct words:
  - 5 writes are accepted (1 popped to the shifter, 4 queued), fifo_level=4, in_ready=0.
  - in_ready returns to 1 on the edge after the next pop.
  - All 5 bytes are transmitted correctly.
- DATA_BITS=7, STOP_BITS=2, write 0x7F -> start, seven 1s, then a stop/high period of 8 cycles (CLKS_PER_BIT=4). The next queued frame's start bit begins exactly after that period.
- Assert rst mid-DATA of 0x00 with 2 words queued -> tx=1 and fifo_level=0 asynchronously. After release, no frame is sent until a new write occurs.
